// File: rtl/boa_stage_mem_pkg.sv
// Shared definitions for the Boa32 MEM stage: trap causes, opcodes, FSM states.
package boa_stage_mem_pkg;

  localparam logic [3:0] RV_ECAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] RV_ECAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] RV_ECAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] RV_ECAUSE_STORE_FAULT    = 4'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  // Opcodes whose RD value is already final when they reach MEM.
  function automatic logic rd_final_in_mem(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LUI) ||
           (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/boa_stage_mem_align.sv
// Byte-lane steering for stores, extraction/extension for loads, alignment check.
module boa_mem_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte        = rdata_i[{addr_i, 3'b000} +: 8];
    rhalf        = rdata_i[{addr_i[1], 4'b0000} +: 16];
    we_o         = '0;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        we_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rbyte[7] & ~funct3_i[2]}}, rbyte};
      end
      2'b01: begin
        we_o         = 4'b0011 << addr_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {{16{rhalf[15] & ~funct3_i[2]}}, rhalf};
        misaligned_o = addr_i[0];
      end
      default: begin
        we_o         = 4'b1111;
        misaligned_o = (addr_i != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/boa_stage_mem.sv
// Boa32 MEM stage: EX/MEM barrier, LOAD/STORE bus access with ready handshake, WB pass-through.
module boa_stage_mem
  import boa_stage_mem_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_valid,
  input  logic [30:0] d_pc,
  input  logic [31:0] d_insn,
  input  logic        d_use_rd,
  input  logic [31:0] d_rs1_val,
  input  logic [31:0] d_rs2_val,
  input  logic        d_trap,
  input  logic [3:0]  d_cause,
  output logic        q_valid,
  output logic [30:0] q_pc,
  output logic [31:0] q_insn,
  output logic        q_use_rd,
  output logic        q_trap,
  output logic [3:0]  q_cause,
  output logic [31:0] q_rd_val,
  output logic        bus_re,
  output logic [3:0]  bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  input  logic        fw_stall_mem,
  output logic        fw_stall_req,
  output logic        fw_rd,
  output logic [31:0] fw_rd_val
);

  logic        r_valid_q, r_trap_q, r_use_rd_q;
  logic [30:0] r_pc_q;
  logic [31:0] r_insn_q, r_rs1_val_q, r_rs2_val_q, r_rdata_q;
  logic [3:0]  r_cause_q;

  mem_state_t  state_q, state_d;
  logic        fault_q, fault_d, kill_q, kill_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_mem, misaligned;
  logic [3:0]  al_we;
  logic [31:0] al_wdata, al_rdata, rdata_word;
  logic        killed, mem_pend, issue, active, ready_hit, load_en, timeout;
  logic        mem_trap, trap_any;

  assign opcode   = r_insn_q[6:0];
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;

  boa_mem_align u_align (
    .funct3_i     (r_insn_q[14:12]),
    .addr_i       (r_rs1_val_q[1:0]),
    .wdata_i      (r_rs2_val_q),
    .rdata_i      (rdata_word),
    .we_o         (al_we),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (misaligned)
  );

  // A clear pulse is remembered so the result stays discarded until the next barrier load.
  assign killed     = clear || kill_q;
  assign mem_pend   = r_valid_q && is_mem && !r_trap_q && !misaligned;
  assign issue      = (state_q == IDLE) && mem_pend && !killed;
  assign active     = issue || (state_q == WAIT);
  assign ready_hit  = active && bus_ready;
  assign rdata_word = ready_hit ? bus_rdata : r_rdata_q;
  assign timeout    = (BUS_TIMEOUT != 0) && (state_q == WAIT) && !bus_ready &&
                      (wait_cnt_q >= BUS_TIMEOUT - 1);

  // A killed access that never issued must not stall; one already on the bus stalls until ready.
  assign fw_stall_req = mem_pend && !(ready_hit || (state_q == DONE)) &&
                        !((state_q == IDLE) && killed);
  assign load_en      = !fw_stall_mem && !fw_stall_req;

  always_comb begin
    state_d    = state_q;
    fault_d    = fault_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: if (issue) begin
        if (bus_ready) begin
          state_d = DONE;
          fault_d = bus_err;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = 32'd1;
        end
      end
      WAIT: if (bus_ready) begin
        state_d = DONE;
        fault_d = bus_err;
      end else if (timeout) begin
        state_d = DONE;
        fault_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 32'd1;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (load_en) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end
    kill_d = load_en ? 1'b0 : killed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fault_q    <= 1'b0;
      kill_q     <= 1'b0;
      wait_cnt_q <= '0;
      r_valid_q  <= 1'b0;
      r_trap_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fault_q    <= fault_d;
      kill_q     <= kill_d;
      wait_cnt_q <= wait_cnt_d;
      if (load_en) begin
        r_valid_q <= d_valid;
        r_trap_q  <= d_trap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      r_pc_q      <= d_pc;
      r_insn_q    <= d_insn;
      r_use_rd_q  <= d_use_rd;
      r_rs1_val_q <= d_rs1_val;
      r_rs2_val_q <= d_rs2_val;
      r_cause_q   <= d_cause;
    end
    if (ready_hit) r_rdata_q <= bus_rdata;
  end

  assign mem_trap = (r_valid_q && is_mem && !r_trap_q && misaligned) ||
                    (ready_hit && bus_err) || ((state_q == DONE) && fault_q);
  assign trap_any = r_trap_q || mem_trap;

  always_comb begin
    q_cause = r_cause_q;
    if (!r_trap_q && mem_trap) begin
      if (misaligned) q_cause = is_load ? RV_ECAUSE_LOAD_MISALIGN : RV_ECAUSE_STORE_MISALIGN;
      else            q_cause = is_load ? RV_ECAUSE_LOAD_FAULT : RV_ECAUSE_STORE_FAULT;
    end
  end

  assign q_valid   = r_valid_q && !killed;
  assign q_trap    = trap_any && !killed;
  assign q_pc      = r_pc_q;
  assign q_insn    = r_insn_q;
  assign q_use_rd  = r_use_rd_q;
  assign q_rd_val  = is_load ? al_rdata : r_rs1_val_q;
  assign fw_rd_val = q_rd_val;
  assign fw_rd     = q_valid && r_use_rd_q && !trap_any &&
                     (rd_final_in_mem(opcode) || (is_load && (ready_hit || (state_q == DONE))));

  assign bus_re    = !rst && active && is_load;
  assign bus_we    = (!rst && active && is_store) ? al_we : '0;
  assign bus_addr  = r_rs1_val_q[31:2];
  assign bus_wdata = al_wdata;

endmodule

// File: tb/tb_boa_stage_mem.sv
// Directed bench for boa_stage_mem with a per-cycle reference model and literal spot checks.
module tb_boa_stage_mem;

  localparam int unsigned BT = 4;

  logic        clk = 1'b0;
  logic        rst, clear, d_valid, d_use_rd, d_trap;
  logic [30:0] d_pc;
  logic [31:0] d_insn, d_rs1_val, d_rs2_val;
  logic [3:0]  d_cause;
  logic        q_valid, q_use_rd, q_trap;
  logic [30:0] q_pc;
  logic [31:0] q_insn, q_rd_val;
  logic [3:0]  q_cause;
  logic        bus_re, bus_ready, bus_err;
  logic [3:0]  bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        fw_stall_mem, fw_stall_req, fw_rd;
  logic [31:0] fw_rd_val;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  boa_stage_mem #(.BUS_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn), .d_use_rd(d_use_rd),
    .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_trap(d_trap), .d_cause(d_cause),
    .q_valid(q_valid), .q_pc(q_pc), .q_insn(q_insn), .q_use_rd(q_use_rd),
    .q_trap(q_trap), .q_cause(q_cause), .q_rd_val(q_rd_val),
    .bus_re(bus_re), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .fw_stall_mem(fw_stall_mem), .fw_stall_req(fw_stall_req),
    .fw_rd(fw_rd), .fw_rd_val(fw_rd_val)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents of the MEM slot plus the progress of its bus access.
  logic        m_valid = 1'b0, m_use_rd = 1'b0, m_trap = 1'b0;
  logic [30:0] m_pc = '0;
  logic [31:0] m_insn = '0, m_rs1 = '0, m_rs2 = '0, m_rdata = '0;
  logic [3:0]  m_cause = '0;
  logic        m_issued = 1'b0, m_done = 1'b0, m_fault = 1'b0, m_killed = 1'b0;
  int unsigned m_waited = 0;

  initial begin : compare
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        ld, st, alu, mis, kill, pend, req, rdy, tmo, stl, mf, ev, et, efw;
    logic [31:0] sz, addr, word, val, erd, ewd;
    logic [3:0]  ewe, ecause;
    forever begin
      @(negedge clk);
      opc  = m_insn[6:0];
      f3   = m_insn[14:12];
      ld   = (opc == 7'h03);
      st   = (opc == 7'h23);
      alu  = opc inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67};
      sz   = (f3[1:0] == 2'd0) ? 32'd1 : (f3[1:0] == 2'd1) ? 32'd2 : 32'd4;
      addr = m_rs1;
      mis  = (ld || st) && ((addr % sz) != 0);
      kill = clear || m_killed;
      pend = m_valid && (ld || st) && !m_trap && !mis;
      req  = m_done ? 1'b0 : (m_issued ? 1'b1 : (pend && !kill));
      rdy  = req && bus_ready;
      tmo  = m_issued && !bus_ready && (BT != 0) && (m_waited + 1 >= BT);
      stl  = pend && !m_done && !rdy && !(!m_issued && kill);
      mf   = (m_valid && (ld || st) && !m_trap && mis) || (rdy && bus_err) || (m_done && m_fault);
      ev   = m_valid && !kill;
      et   = (m_trap || mf) && !kill;
      ecause = m_trap ? m_cause : mis ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
      ewe = '0;
      ewd = '0;
      for (int k = 0; k < 4; k++) begin
        if (k >= addr % 4 && k < addr % 4 + sz) ewe[k] = 1'b1;
        ewd[8*k +: 8] = 8'(m_rs2 >> (8 * (k % sz)));
      end
      word = rdy ? bus_rdata : m_rdata;
      val  = word >> (8 * (addr % 4));
      if (sz == 1) begin
        erd = val & 32'hFF;
        if (!f3[2] && erd[7]) erd = erd | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        erd = val & 32'hFFFF;
        if (!f3[2] && erd[15]) erd = erd | 32'hFFFF_0000;
      end else begin
        erd = word;
      end
      if (!ld) erd = m_rs1;
      efw = ev && m_use_rd && !(m_trap || mf) && (alu || (ld && (rdy || m_done)));

      chk("cmp_bus_re", 32'(bus_re), 32'(!rst && req && ld));
      chk("cmp_bus_we", 32'(bus_we), 32'((!rst && req && st) ? ewe : 4'b0));
      if (!rst && req) chk("cmp_bus_addr", 32'(bus_addr), 32'(addr[31:2]));
      if (!rst && req && st) chk("cmp_bus_wdata", bus_wdata, ewd);
      chk("cmp_stall", 32'(fw_stall_req), 32'(stl));
      chk("cmp_q_valid", 32'(q_valid), 32'(ev));
      chk("cmp_q_trap", 32'(q_trap), 32'(et));
      if (et) chk("cmp_q_cause", 32'(q_cause), 32'(ecause));
      if (ev) begin
        chk("cmp_q_pc", 32'(q_pc), 32'(m_pc));
        chk("cmp_q_insn", q_insn, m_insn);
        chk("cmp_q_use_rd", 32'(q_use_rd), 32'(m_use_rd));
      end
      if (ev && !et && (!ld || rdy || m_done)) begin
        chk("cmp_q_rd_val", q_rd_val, erd);
        chk("cmp_fw_rd_val", fw_rd_val, erd);
      end
      chk("cmp_fw_rd", 32'(fw_rd), 32'(efw));

      @(posedge clk);
      if (rst) begin
        m_valid = 1'b0; m_trap = 1'b0; m_issued = 1'b0;
        m_done = 1'b0; m_fault = 1'b0; m_killed = 1'b0;
      end else begin
        if (rdy) m_rdata = bus_rdata;
        if (!fw_stall_mem && !stl) begin
          m_valid = d_valid; m_pc = d_pc; m_insn = d_insn; m_use_rd = d_use_rd;
          m_rs1 = d_rs1_val; m_rs2 = d_rs2_val; m_trap = d_trap; m_cause = d_cause;
          m_issued = 1'b0; m_done = 1'b0; m_fault = 1'b0; m_killed = 1'b0;
        end else begin
          if (clear) m_killed = 1'b1;
          if (rdy) begin
            m_done = 1'b1; m_fault = bus_err; m_issued = 1'b0;
          end else if (tmo) begin
            m_done = 1'b1; m_fault = 1'b1; m_issued = 1'b0;
          end else if (req) begin
            m_waited = m_issued ? m_waited + 1 : 1;
            m_issued = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'b0, f3, 5'd1, opc};
  endfunction

  task automatic present(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic trap, input logic [3:0] cause);
    d_valid = 1'b1; d_insn = insn; d_pc = rs1[31:1] + 31'h1000; d_use_rd = 1'b1;
    d_rs1_val = rs1; d_rs2_val = rs2; d_trap = trap; d_cause = cause;
    cyc();
    d_valid = 1'b0; d_insn = '0; d_trap = 1'b0; d_cause = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1; clear = 1'b0; d_valid = 1'b0; d_pc = '0; d_insn = '0; d_use_rd = 1'b0;
    d_rs1_val = '0; d_rs2_val = '0; d_trap = 1'b0; d_cause = '0;
    bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = '0; fw_stall_mem = 1'b0;
    cyc(); cyc(); #1;
    chk("reset_q_valid", 32'(q_valid), 32'd0);
    chk("reset_q_trap", 32'(q_trap), 32'd0);
    chk("reset_bus_re", 32'(bus_re), 32'd0);
    rst = 1'b0;
    cyc();

    // LW 0x100, bus answers in the issue cycle
    present(mk(7'h03, 3'd2), 32'h100, 32'h0, 1'b0, 4'd0);
    bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("lw_re", 32'(bus_re), 32'd1);
    chk("lw_addr", 32'(bus_addr), 32'h40);
    chk("lw_stall", 32'(fw_stall_req), 32'd0);
    chk("lw_rd_val", q_rd_val, 32'hDEAD_BEEF);
    chk("lw_fw_rd", 32'(fw_rd), 32'd1);
    cyc(); bus_ready = 1'b0;

    // LB 0x103, ready after 3 stall cycles
    present(mk(7'h03, 3'd0), 32'h103, 32'h0, 1'b0, 4'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      #1; if (fw_stall_req) n++;
      cyc();
    end
    bus_ready = 1'b1; bus_rdata = 32'h80FF_0000; #1;
    chk("lb_stall_cycles", 32'(n), 32'd3);
    chk("lb_stall_end", 32'(fw_stall_req), 32'd0);
    chk("lb_rd_val", q_rd_val, 32'hFFFF_FF80);
    cyc(); bus_ready = 1'b0;

    present(mk(7'h03, 3'd4), 32'h103, 32'h0, 1'b0, 4'd0);
    cyc();
    bus_ready = 1'b1; #1;
    chk("lbu_rd_val", q_rd_val, 32'h0000_0080);
    cyc(); bus_ready = 1'b0;

    // SH 0x202
    present(mk(7'h23, 3'd1), 32'h202, 32'h1234_ABCD, 1'b0, 4'd0);
    bus_ready = 1'b1; #1;
    chk("sh_we", 32'(bus_we), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    cyc(); bus_ready = 1'b0;

    // SW 0x201 misaligned
    present(mk(7'h23, 3'd2), 32'h201, 32'h1111_2222, 1'b0, 4'd0);
    #1;
    chk("sw_mis_we", 32'(bus_we), 32'd0);
    chk("sw_mis_trap", 32'(q_trap), 32'd1);
    chk("sw_mis_cause", 32'(q_cause), 32'd6);
    cyc();

    // LW with no bus answer: timeout
    present(mk(7'h03, 3'd2), 32'h300, 32'h0, 1'b0, 4'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!fw_stall_req) break;
      n++;
      cyc();
    end
    chk("to_stall_cycles", 32'(n), 32'd4);
    chk("to_trap", 32'(q_trap), 32'd1);
    chk("to_cause", 32'(q_cause), 32'd5);
    chk("to_re", 32'(bus_re), 32'd0);
    cyc();

    // clear while IDLE on a store
    present(mk(7'h23, 3'd2), 32'h400, 32'h5555_AAAA, 1'b0, 4'd0);
    clear = 1'b1; #1;
    chk("clr_idle_we", 32'(bus_we), 32'd0);
    chk("clr_idle_valid", 32'(q_valid), 32'd0);
    cyc(); clear = 1'b0;

    // clear while WAIT on a load
    present(mk(7'h03, 3'd2), 32'h404, 32'h0, 1'b0, 4'd0);
    cyc();
    clear = 1'b1; #1;
    chk("clr_wait_re", 32'(bus_re), 32'd1);
    cyc(); clear = 1'b0; #1;
    chk("clr_wait_held", 32'(bus_re), 32'd1);
    chk("clr_wait_stall", 32'(fw_stall_req), 32'd1);
    cyc();
    bus_ready = 1'b1; bus_rdata = 32'h7777_7777; #1;
    chk("clr_wait_valid", 32'(q_valid), 32'd0);
    cyc(); bus_ready = 1'b0;

    // rst during WAIT on a store
    present(mk(7'h23, 3'd2), 32'h500, 32'hCAFE_F00D, 1'b0, 4'd0);
    #1;
    chk("rst_pre_we", 32'(bus_we), 32'hF);
    cyc();
    rst = 1'b1; #1;
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_re", 32'(bus_re), 32'd0);
    cyc();
    rst = 1'b0; #1;
    chk("rst_q_valid", 32'(q_valid), 32'd0);
    chk("rst_q_trap", 32'(q_trap), 32'd0);
    cyc();

    // LH with downstream stall holding the DONE result
    present(mk(7'h03, 3'd1), 32'h602, 32'h0, 1'b0, 4'd0);
    fw_stall_mem = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h8001_1234; #1;
    chk("lh_rd_val", q_rd_val, 32'hFFFF_8001);
    cyc();
    bus_ready = 1'b0; bus_rdata = 32'h0; #1;
    chk("done_hold_rd", q_rd_val, 32'hFFFF_8001);
    chk("done_hold_re", 32'(bus_re), 32'd0);
    chk("done_hold_fw", 32'(fw_rd), 32'd1);
    cyc();
    fw_stall_mem = 1'b0;
    cyc();

    // OP-IMM pass-through, then an incoming trap on a load
    present(mk(7'h13, 3'd0), 32'h55, 32'h0, 1'b0, 4'd0);
    #1;
    chk("alu_rd_val", q_rd_val, 32'h55);
    chk("alu_fw_rd", 32'(fw_rd), 32'd1);
    cyc();
    present(mk(7'h03, 3'd2), 32'h100, 32'h0, 1'b1, 4'd2);
    #1;
    chk("intrap_re", 32'(bus_re), 32'd0);
    chk("intrap_cause", 32'(q_cause), 32'd2);
    cyc();

    // SB with bus error
    present(mk(7'h23, 3'd0), 32'h701, 32'h0000_005A, 1'b0, 4'd0);
    bus_ready = 1'b1; bus_err = 1'b1; #1;
    chk("sb_we", 32'(bus_we), 32'h2);
    chk("sb_wdata", bus_wdata, 32'h5A5A_5A5A);
    chk("sb_err_cause", 32'(q_cause), 32'd7);
    cyc(); bus_ready = 1'b0; bus_err = 1'b0;

    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
